z_event_fifo: RTL
=================

// Module: z_event_fifo
// PURPOSE
//  Downstream consumer of the sequence-detector FSM output z_o. Timestamps each
//  rising edge of z (start of a detection) with a free-running cycle counter and
//  queues the timestamp in a small FIFO.
//  A host drains the FIFO with a first-word-fall-through read port. Overflow is
//  flagged sticky, and dropped events are counted.
// PARAMETERS
//  TS_W    16  timestamp / cycle-counter width (bits); counter wraps mod 2^TS_W
//  DEPTH    8  FIFO entries; must be a power of 2, >= 2
//  AW       3  log2(DEPTH)
//  DROP_W   8  width of the saturating dropped-event counter
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  z_i        in   1       detector output (z_o of the FSM), synchronous to clk
//  rd_en      in   1       pop request; ignored when empty
//  clr_ovf    in   1       clears ovf_o and drop_cnt_o
//  rd_data_o  out  TS_W    head-of-FIFO timestamp; valid only when empty_o==0
//  empty_o    out  1       FIFO empty
//  full_o     out  1       FIFO full
//  count_o    out  AW+1    occupancy, 0..DEPTH
//  ovf_o      out  1       sticky: an event was dropped
//  drop_cnt_o out  DROP_W  dropped events, saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release by clk)
//   - ts counter, z_q, pointers, ovf_o, drop_cnt_o <= 0.
//   - empty_o=1, full_o=0, count_o=0. rd_data_o is don't-care.
//   - Reset mid-operation discards all queued entries.
//  Timestamp
//   - ts increments by 1 every clk. The first post-reset edge makes ts=1.
//   - Wraps 2^TS_W-1 -> 0 with no flag.
//  Edge detection
//   - z_q <= z_i each cycle; push = z_i & ~z_q.
//   - One entry per high run, regardless of run length.
//   - z_i already high when reset releases counts as an edge: z_q resets to 0.
//  Write
//   - On a push cycle, mem[wr_ptr] <= ts (value before this edge's increment)
//     and wr_ptr++.
//  Read (FWFT)
//   - rd_data_o = mem[rd_ptr[AW-1:0]], combinational from storage.
//   - rd_en & ~empty_o: rd_ptr++ at the edge.
//   - rd_en when empty: no effect and no error.
//  Pointers
//   - AW+1 bits with a wrap bit.
//   - empty = (wr_ptr==rd_ptr).
//   - full = addr bits equal & wrap bits differ.
//   - count = wr_ptr - rd_ptr.
//   - Flags are registered-state derived, so they are valid the cycle after the edge.
//  Simultaneous events
//   - push & pop, not full: both occur, count unchanged.
//   - push & pop while full: pop frees the slot, push is accepted, no overflow.
//   - push while empty: the entry is visible on rd_data_o the next cycle, not same-cycle.
//   - push while full without pop: entry dropped. ovf_o <= 1.
//     drop_cnt_o <= drop_cnt_o+1, saturating.
//   - clr_ovf same cycle as a drop: clear wins, and the drop is not counted.
//  Latency
//   - z_i rise at edge N (sampled) -> empty_o falls after edge N,
//     with rd_data_o = ts sampled at edge N.
// TESTING (20 ns clk; rst_n low 6-36 ns)
//  1 Reset
//    - rst_n low mid-run with 3 entries queued -> empty_o=1, count_o=0,
//      ovf_o=0 immediately (async).
//  2 Single event
//    - z_i 0->1 sampled when ts=5 -> next cycle empty_o=0, rd_data_o=5,
//      count_o=1.
//    - Pulse rd_en -> empty_o=1.
//  3 Run length
//    - z_i held high 3 cycles, then low, then high 1 cycle -> exactly 2 entries,
//      with timestamps 4 cycles apart.
//  4 Fill / overflow
//    - 10 isolated pulses, no reads (DEPTH=8) -> full_o=1, count_o=8, ovf_o=1,
//      drop_cnt_o=2.
//    - clr_ovf -> ovf_o=0, drop_cnt_o=0, entries intact.
//  5 Full + simultaneous
//    - FIFO full, push with rd_en in the same cycle -> count_o stays 8,
//      ovf_o stays 0.
//    - Oldest entry popped, new timestamp is last.
//  6 Wrap
//    - TS_W=4 with >16 cycles between events -> stored ts equals cycle mod 16.
//    - 20 push/pop pairs -> pointer wrap preserves FIFO order.

Source files
------------

// File: rtl/z_event_fifo.sv
// Timestamps each rising edge of z_i into a FWFT FIFO; the entry is visible the cycle after the edge.
// No backpressure: a push into a full FIFO is dropped, and the drop is flagged and counted.
module z_event_fifo #(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              z_i,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [TS_W-1:0]   rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [TS_W-1:0]   TS_ONE   = 1;
  localparam logic [AW:0]       PTR_ONE  = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              z_q, z_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic empty, full, push, pop, accept, drop;

  // Extra wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  always_comb begin
    push   = z_i & ~z_q;
    pop    = rd_en & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    ts_d       = ts_q + TS_ONE;
    z_d        = z_i;
    wr_ptr_d   = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      z_q        <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      z_q        <= z_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
  end

  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = empty;
  assign full_o     = full;
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
